// File: rtl/kh32_demux_pkg.sv
// ---------------------------------------------------------------------------
// kh32_demux_pkg
// Shared constants and helpers for the 1-to-16 lane demultiplexer.
//   LANES  : number of output lanes (16)
//   SEL_W  : width of the lane select (4)
//   DATA_W : lane data width (32, the only supported width)
//   CNT_W  : width of the occupancy count, wide enough for 0..LANES
//   popcount() : number of set bits in a lane-wide flag vector
// ---------------------------------------------------------------------------
package kh32_demux_pkg;

   localparam int LANES  = 16;
   localparam int SEL_W  = 4;
   localparam int DATA_W = 32;
   localparam int CNT_W  = 5;

   // Counts occupied lanes; used to produce the registered occupancy count.
   function automatic logic [CNT_W-1:0] popcount(input logic [LANES-1:0] flags);
      logic [CNT_W-1:0] total;
      total = '0;
      for (int i = 0; i < LANES; i++) begin
         total = total + CNT_W'(flags[i]);
      end
      return total;
   endfunction

endpackage

// File: rtl/demux_lane_reg.sv
// ---------------------------------------------------------------------------
// demux_lane_reg
// One-entry holding register for a single demux output lane.
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset (clears flag and data)
//   load      : write load_data into the lane on the next edge
//   drain     : lane consumer takes the held word this cycle
//   load_data : word to store
//   full      : lane holds a valid word
//   data      : held word (keeps its last value while empty)
// ---------------------------------------------------------------------------
module demux_lane_reg
   import kh32_demux_pkg::*;
#(
   parameter int LANE_W = DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              drain,
   input  logic [LANE_W-1:0] load_data,
   output logic              full,
   output logic [LANE_W-1:0] data
);

   // A load always wins over a drain, so a word leaving and a new word
   // arriving on the same edge leaves the lane full with the new word.
   // This is what gives one word per cycle of throughput per lane.
   // Data is only written on a load, so it stays stable while the lane
   // waits for its consumer and keeps its last value once drained.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full <= 1'b0;
         data <= '0;
      end else if (load) begin
         full <= 1'b1;
         data <= load_data;
      end else if (drain) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/demux_1_to_16_32bit.sv
// ---------------------------------------------------------------------------
// demux_1_to_16_32bit
// Routes a valid/ready upstream word to one of 16 one-entry output lanes.
// Optional build macro DEMUX_BCAST_EN adds the in_bcast port, which writes
// the word into all 16 lanes at once (only when every lane can take it).
// Ports:
//   clk, rst  : clock (rising edge) and asynchronous active-high reset
//   in_valid  : upstream word valid
//   in_ready  : word accepted this cycle (combinational, independent of in_valid)
//   in_sel    : destination lane 0..15 (ignored during a broadcast)
//   in_data   : upstream word
//   in_bcast  : broadcast request (DEMUX_BCAST_EN builds only)
//   out_valid : bit k set when lane k holds a word
//   out_ready : bit k set when the lane k consumer takes its word
//   out_data  : lane k occupies bits [32k+31:32k]
//   occ_cnt   : registered number of occupied lanes, 0..16
// ---------------------------------------------------------------------------
module demux_1_to_16_32bit
   import kh32_demux_pkg::*;
#(
   parameter int DATA_W = kh32_demux_pkg::DATA_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [SEL_W-1:0]        in_sel,
   input  logic [DATA_W-1:0]       in_data,
`ifdef DEMUX_BCAST_EN
   input  logic                    in_bcast,
`endif
   output logic [LANES-1:0]        out_valid,
   input  logic [LANES-1:0]        out_ready,
   output logic [LANES*DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]        occ_cnt
);

   logic [LANES-1:0] full;
   logic [LANES-1:0] lane_free;
   logic [LANES-1:0] sel_onehot;
   logic [LANES-1:0] load;
   logic [LANES-1:0] next_full;
   logic             accept;

   // A lane can take a word if it is empty or its current word leaves now.
   assign lane_free  = ~full | out_ready;
   assign sel_onehot = {{(LANES-1){1'b0}}, 1'b1} << in_sel;

`ifdef DEMUX_BCAST_EN
   // A broadcast needs room in every lane at once; in_sel plays no part.
   assign in_ready = in_bcast ? (&lane_free) : lane_free[in_sel];
`else
   assign in_ready = lane_free[in_sel];
`endif

   assign accept = in_valid & in_ready;

   // Decode the accepted word into per-lane load strobes.
   always_comb begin
      load = '0;
      if (accept) begin
`ifdef DEMUX_BCAST_EN
         load = in_bcast ? {LANES{1'b1}} : sel_onehot;
`else
         load = sel_onehot;
`endif
      end
   end

   // Flag values the lanes will hold after this edge, so the occupancy
   // count lands on the same edge as the flags themselves.
   assign next_full = load | (full & ~out_ready);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ_cnt <= '0;
      end else begin
         occ_cnt <= popcount(next_full);
      end
   end

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      demux_lane_reg #(
         .LANE_W    (DATA_W)
      ) u_lane (
         .clk       (clk),
         .rst       (rst),
         .load      (load[k]),
         .drain     (out_ready[k]),
         .load_data (in_data),
         .full      (full[k]),
         .data      (out_data[k*DATA_W +: DATA_W])
      );
   end

   assign out_valid = full;

endmodule

// File: tb/tb_demux_1_to_16_32bit.sv
// ---------------------------------------------------------------------------
// tb_demux_1_to_16_32bit
// Directed scenarios followed by random unicast traffic. The reference model
// is one queue of expected words per lane: the driver pushes each accepted
// word, and a negedge monitor checks flags, occupancy, ready and pops/compares
// every word a consumer takes.
// ---------------------------------------------------------------------------
module tb_demux_1_to_16_32bit;
   import kh32_demux_pkg::*;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    in_valid;
   logic                    in_ready;
   logic [SEL_W-1:0]        in_sel;
   logic [DATA_W-1:0]       in_data;
`ifdef DEMUX_BCAST_EN
   logic                    in_bcast;
`endif
   logic [LANES-1:0]        out_valid;
   logic [LANES-1:0]        out_ready;
   logic [LANES*DATA_W-1:0] out_data;
   logic [CNT_W-1:0]        occ_cnt;

   int checks = 0;
   int passes = 0;
   bit mon_en = 1'b0;

   logic [DATA_W-1:0] exp_q [LANES][$];
   logic [LANES-1:0]  mon_valid;
   int                mon_cnt;

   demux_1_to_16_32bit #(
      .DATA_W    (32)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sel    (in_sel),
      .in_data   (in_data),
`ifdef DEMUX_BCAST_EN
      .in_bcast  (in_bcast),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occ_cnt   (occ_cnt)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   function automatic logic [DATA_W-1:0] laneData(input int k);
      return out_data[k*DATA_W +: DATA_W];
   endfunction

   // Drives the upstream and consumer-side inputs.
   task automatic applyStimulus(input logic v, input logic [SEL_W-1:0] sel,
                                input logic [DATA_W-1:0] d, input logic [LANES-1:0] ordy);
      in_valid  = v;
      in_sel    = sel;
      in_data   = d;
      out_ready = ordy;
`ifdef DEMUX_BCAST_EN
      in_bcast  = 1'b0;
`endif
   endtask

   // Compares one observed value with its expected value and tallies it.
   task automatic checkOutput(input string name, input logic [511:0] actual,
                              input logic [511:0] expected);
      checks++;
      if (actual === expected) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: compares DUT outputs with the per-lane queues just before
   // each edge, then retires the words consumed on that edge.
   always begin
      @(negedge clk);
      if (mon_en) begin
         mon_valid = '0;
         mon_cnt   = 0;
         for (int k = 0; k < LANES; k++) begin
            if (exp_q[k].size() != 0) begin
               mon_valid[k] = 1'b1;
               mon_cnt++;
            end
         end
         checkOutput("out_valid", 512'(out_valid), 512'(mon_valid));
         checkOutput("occ_cnt", 512'(occ_cnt), 512'(mon_cnt));
         checkOutput("in_ready", 512'(in_ready),
                     512'(!mon_valid[in_sel] || out_ready[in_sel]));
         for (int k = 0; k < LANES; k++) begin
            if (mon_valid[k] && out_ready[k]) begin
               checkOutput($sformatf("lane%0d_word", k), 512'(laneData(k)),
                           512'(exp_q[k].pop_front()));
            end
         end
      end
   end

   initial begin
      // Reset state
      rst = 1'b1;
      applyStimulus(1'b0, '0, '0, '0);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_out_valid", 512'(out_valid), 512'(0));
      checkOutput("reset_occ_cnt", 512'(occ_cnt), 512'(0));
      checkOutput("reset_out_data", out_data, 512'(0));
      @(negedge clk);
      rst = 1'b0;

      // Single unicast write to lane 5
      applyStimulus(1'b1, 4'h5, 32'hDEAD_BEEF, '0);
      #1;
      checkOutput("first_in_ready", 512'(in_ready), 512'(1));
      tick();
      applyStimulus(1'b0, '0, '0, '0);
      checkOutput("uni_out_valid", 512'(out_valid), 512'(16'h0020));
      checkOutput("uni_lane5", 512'(laneData(5)), 512'(32'hDEAD_BEEF));
      checkOutput("uni_occ_cnt", 512'(occ_cnt), 512'(1));

      // Stalled lane refuses, then drain-and-reload on one edge
      applyStimulus(1'b1, 4'h5, 32'hCAFE_F00D, '0);
      #1;
      checkOutput("stall_in_ready", 512'(in_ready), 512'(0));
      tick();
      checkOutput("stall_lane5", 512'(laneData(5)), 512'(32'hDEAD_BEEF));
      out_ready = 16'h0020;
      #1;
      checkOutput("reload_in_ready", 512'(in_ready), 512'(1));
      tick();
      applyStimulus(1'b0, '0, '0, '0);
      checkOutput("reload_lane5", 512'(laneData(5)), 512'(32'hCAFE_F00D));
      checkOutput("reload_out_valid", 512'(out_valid), 512'(16'h0020));
      checkOutput("reload_occ_cnt", 512'(occ_cnt), 512'(1));
      applyStimulus(1'b0, '0, '0, 16'hFFFF);
      tick();
      checkOutput("drain_out_valid", 512'(out_valid), 512'(0));
      checkOutput("drain_occ_cnt", 512'(occ_cnt), 512'(0));

      // Fill every lane back-to-back, then a further write is refused
      for (int k = 0; k < LANES; k++) begin
         applyStimulus(1'b1, SEL_W'(k), 32'h1000_0000 + 32'(k), '0);
         tick();
      end
      applyStimulus(1'b0, '0, '0, '0);
      checkOutput("fill_out_valid", 512'(out_valid), 512'(16'hFFFF));
      checkOutput("fill_occ_cnt", 512'(occ_cnt), 512'(16));
      for (int k = 0; k < LANES; k++) begin
         checkOutput($sformatf("fill_lane%0d", k), 512'(laneData(k)),
                     512'(32'h1000_0000 + 32'(k)));
      end
      applyStimulus(1'b1, SEL_W'($urandom_range(0, LANES-1)), 32'h1234_5678, '0);
      #1;
      checkOutput("full_in_ready", 512'(in_ready), 512'(0));
      tick();
      checkOutput("full_occ_cnt", 512'(occ_cnt), 512'(16));
      applyStimulus(1'b0, '0, '0, 16'hFFFF);
      tick();
      checkOutput("fill_drain", 512'(out_valid), 512'(0));

`ifdef DEMUX_BCAST_EN
      // Broadcast waits for a stalled lane, then fills all lanes
      applyStimulus(1'b1, 4'h9, 32'h0000_0099, '0);
      tick();
      applyStimulus(1'b1, 4'h3, 32'h0000_00A5, '0);
      in_bcast = 1'b1;
      #1;
      checkOutput("bcast_blocked", 512'(in_ready), 512'(0));
      tick();
      checkOutput("bcast_hold", 512'(out_valid), 512'(16'h0200));
      out_ready = 16'h0200;
      #1;
      checkOutput("bcast_ready", 512'(in_ready), 512'(1));
      tick();
      applyStimulus(1'b0, '0, '0, '0);
      checkOutput("bcast_out_valid", 512'(out_valid), 512'(16'hFFFF));
      checkOutput("bcast_occ_cnt", 512'(occ_cnt), 512'(16));
      for (int k = 0; k < LANES; k++) begin
         checkOutput($sformatf("bcast_lane%0d", k), 512'(laneData(k)),
                     512'(32'h0000_00A5));
      end
      applyStimulus(1'b0, '0, '0, 16'hFFFF);
      tick();
`endif

      // Asynchronous reset mid-stream with three lanes full
      applyStimulus(1'b1, 4'h2, 32'h2222_2222, '0);
      tick();
      applyStimulus(1'b1, 4'h7, 32'h7777_7777, '0);
      tick();
      applyStimulus(1'b1, 4'hB, 32'hBBBB_BBBB, '0);
      tick();
      applyStimulus(1'b0, '0, '0, '0);
      checkOutput("three_occ_cnt", 512'(occ_cnt), 512'(3));
      #2;
      rst = 1'b1;
      #1;
      checkOutput("midrst_out_valid", 512'(out_valid), 512'(0));
      checkOutput("midrst_occ_cnt", 512'(occ_cnt), 512'(0));
      checkOutput("midrst_out_data", out_data, 512'(0));
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(1'b1, 4'h3, 32'h3333_3333, '0);
      tick();
      applyStimulus(1'b0, '0, '0, '0);
      checkOutput("postrst_out_valid", 512'(out_valid), 512'(16'h0008));
      checkOutput("postrst_lane3", 512'(laneData(3)), 512'(32'h3333_3333));
      applyStimulus(1'b0, '0, '0, 16'hFFFF);
      tick();

      // Random unicast traffic against the per-lane queues
      mon_en = 1'b1;
      for (int n = 0; n < 10000; n++) begin
         @(posedge clk);
         #1;
         applyStimulus(($urandom_range(0, 9) < 7), SEL_W'($urandom_range(0, LANES-1)),
                       $urandom(), LANES'($urandom()));
         @(negedge clk);
         #1;
         if (in_valid && in_ready) begin
            exp_q[in_sel].push_back(in_data);
         end
      end
      @(posedge clk);
      #1;
      applyStimulus(1'b0, '0, '0, 16'hFFFF);
      repeat (3) tick();
      mon_en = 1'b0;
      checkOutput("final_out_valid", 512'(out_valid), 512'(0));
      for (int k = 0; k < LANES; k++) begin
         checkOutput($sformatf("final_q%0d_left", k), 512'(exp_q[k].size()), 512'(0));
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/demux_1_to_16_32bit.md
DEMUX_1_TO_16_32BIT -- requirements
Module: demux_1_to_16_32bit

Interface
REQ-001 Parameter DATA_W, default 32: lane data width; only 32 is supported.
REQ-002 clk  input  1: single clock; all state updates on its rising edge.
REQ-003 rst  input  1: reset, asynchronous, active-high.
REQ-004 in_valid  input  1: the upstream word is valid.
REQ-005 in_ready  output  1: the block accepts the upstream word this cycle.
REQ-006 in_sel  input  4: destination lane index, 0..15.
REQ-007 in_data  input  32: upstream word.
REQ-008 in_bcast  input  1: broadcast request; present only with DEMUX_BCAST_EN.
REQ-009 out_valid  output  16: bit k means lane k holds a word.
REQ-010 out_ready  input  16: bit k means the lane k consumer takes the word this cycle.
REQ-011 out_data  output  512: lane k is bits [32k+31:32k].
REQ-012 occ_cnt  output  5: number of occupied lanes, 0..16.

Function
REQ-013 Each lane SHALL be a one-entry holding register with a full flag; out_valid[k] = full[k].
REQ-014 Input acceptance SHALL occur when in_valid && in_ready are both high.
REQ-015 Unicast in_ready SHALL be ~full[in_sel] | out_ready[in_sel], combinational with no dependency on in_valid.
REQ-016 On accept, the lane in_sel SHALL load in_data and set full on the next edge; latency is 1 cycle from input to out_valid.
REQ-017 A lane k handshake (out_valid[k] && out_ready[k]) SHALL clear full[k] unless the same edge reloads lane k.
REQ-018 When a lane is full and drains on the same edge as a new write to it, the lane SHALL hold the new word with full=1, giving one word per cycle of throughput per lane.
REQ-019 Lanes not addressed SHALL hold their data and flags unchanged; out_data[k] SHALL be stable while out_valid[k]=1 and out_ready[k]=0.
REQ-020 out_data of an empty lane SHALL keep its last value and is don't-care to consumers.
REQ-021 occ_cnt SHALL be the registered popcount of full, updated on the same edge as the flags.
REQ-022 in_sel SHALL be a don't-care when in_valid=0; no state changes without an accept.

Reset
REQ-023 Asserting rst SHALL immediately clear every full flag, set out_valid to 0 and occ_cnt to 0, and set every lane's out_data to 32'h0000_0000.
REQ-024 A word in flight at reset assertion SHALL be dropped.
REQ-025 The first accept SHALL be possible on the first rising edge after rst deasserts.

Configuration
REQ-026 With macro DEMUX_BCAST_EN defined, the in_bcast port SHALL exist.
REQ-027 When in_bcast=1, in_ready SHALL be the AND over k of (~full[k] | out_ready[k]), and an accept SHALL load in_data into all 16 lanes.
REQ-028 When in_bcast=1, in_sel SHALL be ignored.
REQ-029 Without DEMUX_BCAST_EN, the in_bcast port SHALL be absent and only unicast behaviour SHALL exist.

Structure
REQ-030 A shared package kh32_demux_pkg SHALL hold LANES=16, SEL_W=4 and DATA_W=32.
REQ-031 A sub-module demux_lane_reg (one-entry register: load, drain, full, data) SHALL be instantiated 16 times.
REQ-032 The top level SHALL contain only decode, ready selection and the popcount.

Verification
REQ-033 Reset, then in_valid=1, in_sel=4'h5, in_data=32'hDEAD_BEEF with out_ready=0 -> next cycle out_valid=16'h0020, lane 5 = 32'hDEAD_BEEF, occ_cnt=1.
REQ-034 Lane 5 full with out_ready[5]=0, then a second write to sel 5 -> in_ready=0 and lane 5 is unchanged; raising out_ready[5] -> in_ready=1 the same cycle and the new word is loaded with full kept.
REQ-035 Back-to-back writes to sel 0..15 with data=32'h1000_0000+k and out_ready=0 -> after 16 cycles out_valid=16'hFFFF and occ_cnt=16; a further write to any lane is refused.
REQ-036 rst asserted mid-stream with 3 lanes full -> out_valid=0 and occ_cnt=0 before the next edge, and all out_data read 0.
REQ-037 With DEMUX_BCAST_EN: lane 9 full and stalled, in_bcast=1, data=32'h0000_00A5 -> in_ready=0; after lane 9 drains -> all 16 lanes hold 32'h0000_00A5 and occ_cnt=16.
REQ-038 Random unicast traffic with random out_ready over 10k cycles -> a scoreboard sees no loss, no duplication and in-order delivery per lane.
